button_debounce: RTL and testbench
==================================

BUTTON_DEBOUNCE -- requirements
Module: button_debounce

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, giving the consecutive synchronized cycles needed to accept a level change (legal range >= 2).
REQ-002 The block SHALL have parameter LONG_CYCLES, default 1024, giving the cycles o_level must stay high before o_long fires (legal range >= 1).
REQ-003 The block SHALL have parameter ACTIVE_LOW, default 1; when set, raw input 0 means pressed.
REQ-004 The block SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-005 The block SHALL have port i_reset_n, input, 1 bit: synchronous, active-low reset.
REQ-006 The block SHALL have port i_btn, input, 1 bit: raw asynchronous button pin.
REQ-007 The block SHALL have port o_level, output, 1 bit: debounced pressed level, 1 = pressed.
REQ-008 The block SHALL have port o_click, output, 1 bit: one-cycle pulse on each accepted press; it feeds the downstream click-driven selector's click input.
REQ-009 The block SHALL have port o_release, output, 1 bit: one-cycle pulse on each accepted release.
REQ-010 The block SHALL have port o_long, output, 1 bit: one-cycle long-press pulse.

Function
REQ-011 Normalized input p = ACTIVE_LOW ? ~i_btn : i_btn SHALL pass through a two-flop synchronizer; its second-stage output is s.
REQ-012 Debounce counter cnt, width $clog2(DEBOUNCE_CYCLES), SHALL update on every edge: s==o_level -> cnt=0; s!=o_level and cnt==DEBOUNCE_CYCLES-1 -> o_level toggles, cnt=0; otherwise cnt+1.
REQ-013 If edge k is the first edge that samples a new stable i_btn value, o_level SHALL change at edge k+DEBOUNCE_CYCLES+1.
REQ-014 An input excursion shorter than DEBOUNCE_CYCLES synchronized cycles SHALL clear cnt and SHALL produce no output change.
REQ-015 o_click SHALL be registered and SHALL be high for exactly the one cycle after the edge at which o_level goes 0->1, coincident with the first high cycle of o_level.
REQ-016 o_release SHALL likewise be high for exactly one cycle, coincident with the first low cycle of o_level after a 1->0 change.
REQ-017 o_click and o_release SHALL never be high in the same cycle, and at most one SHALL fire per DEBOUNCE_CYCLES cycles.
REQ-018 All outputs SHALL be registered, with no combinational path from i_btn to any output.

Reset
REQ-019 While i_reset_n==0 at an edge, the synchronizer flops, cnt, o_level, o_click, o_release, o_long and the hold counter SHALL all be cleared to 0.
REQ-020 A button held pressed through reset deassertion SHALL produce o_click at edge DEBOUNCE_CYCLES+2 after the first edge with i_reset_n==1; no pulse SHALL be emitted during reset.
REQ-021 Reset asserted mid-debounce or mid-hold SHALL abort the operation with no pulse emitted.

Configuration
REQ-022 Macro BUTTON_DEBOUNCE_LONG_PRESS_EN SHALL control the long-press feature.
REQ-023 With BUTTON_DEBOUNCE_LONG_PRESS_EN defined, hold counter hcnt, width $clog2(LONG_CYCLES+1), SHALL increment each cycle o_level==1 and saturate at LONG_CYCLES.
REQ-024 With BUTTON_DEBOUNCE_LONG_PRESS_EN defined, o_long SHALL pulse one cycle when hcnt reaches LONG_CYCLES, at most once per press.
REQ-025 With BUTTON_DEBOUNCE_LONG_PRESS_EN defined, hcnt SHALL clear to 0 when o_level==0.
REQ-026 Without BUTTON_DEBOUNCE_LONG_PRESS_EN, hcnt SHALL not exist, o_long SHALL be tied to 0, and the port list SHALL be unchanged.

Verification
REQ-027 Bench SHALL cover: DEBOUNCE_CYCLES=4, ACTIVE_LOW=1, i_btn 1->0 sampled at edge 10 and held -> o_level=1 and o_click=1 after edge 15; o_click low after edge 16.
REQ-028 Bench SHALL cover: DEBOUNCE_CYCLES=4, a 3-cycle low glitch on i_btn -> o_level stays 0; o_click and o_release never assert.
REQ-029 Bench SHALL cover: DEBOUNCE_CYCLES=4, press then release each held for 20 cycles, with bounce of alternating 1-cycle toggles for 6 cycles at each edge -> exactly one o_click and one o_release; o_release sits 5 edges after the stable release sample.
REQ-030 Bench SHALL cover: with BUTTON_DEBOUNCE_LONG_PRESS_EN and LONG_CYCLES=8, press held for 30 cycles -> one o_long pulse on the 8th cycle after o_level rises, no second pulse.
REQ-031 Bench SHALL cover: the same 30-cycle hold without the macro -> o_long constantly 0.
REQ-032 Bench SHALL cover: i_reset_n=0 for one edge while cnt==2 -> all outputs 0; with the button still held, o_click appears at post-reset edge DEBOUNCE_CYCLES+2.

Source files
------------

// File: rtl/button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce
// Description : Two-flop synchronizer followed by a consecutive-sample
//               debouncer for a mechanical push button. Produces the clean
//               pressed level plus one-cycle press / release pulses and an
//               optional long-press pulse.
//               Define BUTTON_DEBOUNCE_LONG_PRESS_EN to build the long-press
//               hold counter; otherwise o_long is tied low.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 1024,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic i_reset_n,
  input  logic i_btn,
  output logic o_level,
  output logic o_click,
  output logic o_release,
  output logic o_long
);

  localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // Raw pin normalized so that 1 always means "pressed".
  logic w_pressed;
  assign w_pressed = ACTIVE_LOW ? ~i_btn : i_btn;

  logic             sync1_q;
  logic             sync2_q;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             level_q;
  logic             level_d;
  logic             click_q;
  logic             click_d;
  logic             release_q;
  logic             release_d;

  // Debounce decision: count consecutive disagreeing samples, flip on the last one.
  always_comb begin
    cnt_d     = cnt_q;
    level_d   = level_q;
    click_d   = 1'b0;
    release_d = 1'b0;
    if (sync2_q == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      level_d   = ~level_q;
      cnt_d     = '0;
      // Pulses are launched on the same edge as the level flip so they
      // line up with the first cycle of the new level.
      click_d   = ~level_q;
      release_d = level_q;
    end else begin
      cnt_d = cnt_q + CNT_ONE;
    end
  end

  // Synchronizer, debounce counter and registered level/pulse outputs.
  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      click_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync1_q   <= w_pressed;
      sync2_q   <= sync1_q;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      click_q   <= click_d;
      release_q <= release_d;
    end
  end

  assign o_level   = level_q;
  assign o_click   = click_q;
  assign o_release = release_q;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam int               HCNT_W    = $clog2(LONG_CYCLES + 1);
  localparam logic [HCNT_W-1:0] HCNT_MAX  = HCNT_W'(LONG_CYCLES);
  localparam logic [HCNT_W-1:0] HCNT_FIRE = HCNT_W'(LONG_CYCLES - 1);
  localparam logic [HCNT_W-1:0] HCNT_ONE  = HCNT_W'(1);

  logic [HCNT_W-1:0] hcnt_q;
  logic [HCNT_W-1:0] hcnt_d;
  logic              long_q;
  logic              long_d;

  // Hold counter saturates, so the fire value is crossed only once per press.
  always_comb begin
    hcnt_d = '0;
    long_d = 1'b0;
    if (level_q) begin
      hcnt_d = (hcnt_q == HCNT_MAX) ? hcnt_q : (hcnt_q + HCNT_ONE);
      long_d = (hcnt_q == HCNT_FIRE);
    end
  end

  // Hold counter and registered long-press pulse.
  always_ff @(posedge clk) begin
    if (!i_reset_n) begin
      hcnt_q <= '0;
      long_q <= 1'b0;
    end else begin
      hcnt_q <= hcnt_d;
      long_q <= long_d;
    end
  end

  assign o_long = long_q;
`else
  assign o_long = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_button_debounce.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_debounce
// Description : Self-checking bench for button_debounce (DEBOUNCE_CYCLES=4,
//               LONG_CYCLES=8, active-low pin). Directed scenarios followed
//               by randomized pin activity against a behavioural model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_debounce;

  localparam int D = 4;
  localparam int L = 8;

`ifdef BUTTON_DEBOUNCE_LONG_PRESS_EN
  localparam bit LONG_ON = 1'b1;
`else
  localparam bit LONG_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic i_reset_n = 1'b0;
  logic i_btn = 1'b1;
  logic o_level;
  logic o_click;
  logic o_release;
  logic o_long;

  button_debounce #(
    .DEBOUNCE_CYCLES (D),
    .LONG_CYCLES     (L),
    .ACTIVE_LOW      (1'b1)
  ) dut (
    .clk       (clk),
    .i_reset_n (i_reset_n),
    .i_btn     (i_btn),
    .o_level   (o_level),
    .o_click   (o_click),
    .o_release (o_release),
    .o_long    (o_long)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_click = 0;
  int n_rel = 0;
  int n_long = 0;

  // Behavioural model: the pressed level flips once the synchronized pin has
  // disagreed with it on D consecutive edges; long press fires after the level
  // has been high on L consecutive edges.
  bit pipe0 = 1'b0;
  bit pipe1 = 1'b0;
  bit m_level = 1'b0;
  bit m_click = 1'b0;
  bit m_rel = 1'b0;
  bit m_long = 1'b0;
  int m_run = 0;
  int m_hold = 0;

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit p;
    bit s_seen;
    bit lvl_old;
    @(posedge clk);
    p = ~i_btn;
    if (!i_reset_n) begin
      pipe0 = 1'b0; pipe1 = 1'b0;
      m_level = 1'b0; m_click = 1'b0; m_rel = 1'b0; m_long = 1'b0;
      m_run = 0; m_hold = 0;
    end else begin
      s_seen  = pipe1;
      lvl_old = m_level;
      m_click = 1'b0;
      m_rel   = 1'b0;
      if (s_seen != lvl_old) begin
        m_run++;
        if (m_run == D) begin
          m_level = ~lvl_old;
          m_run   = 0;
          m_click = m_level;
          m_rel   = ~m_level;
        end
      end else begin
        m_run = 0;
      end
      if (lvl_old) begin
        m_hold++;
        m_long = (m_hold == L);
      end else begin
        m_hold = 0;
        m_long = 1'b0;
      end
      pipe1 = pipe0;
      pipe0 = p;
    end
    cyc++;
    #1;
    chk("model_level", o_level, m_level);
    chk("model_click", o_click, m_click);
    chk("model_release", o_release, m_rel);
    chk("model_long", o_long, m_long & LONG_ON);
    chk("click_release_exclusive", o_click & o_release, 1'b0);
    if (o_click)   n_click++;
    if (o_release) n_rel++;
    if (o_long)    n_long++;
  endtask

  task automatic do_reset(input int n);
    i_reset_n = 1'b0;
    repeat (n) step();
    i_reset_n = 1'b1;
    cyc = 0;
    n_click = 0;
    n_rel = 0;
    n_long = 0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_level"}, o_level, 1'b0);
    chk({tag, "_click"}, o_click, 1'b0);
    chk({tag, "_release"}, o_release, 1'b0);
    chk({tag, "_long"}, o_long, 1'b0);
  endtask

  initial begin
    int k;
    int e;
    int len;

    // Reset state, then press sampled at edge 10.
    i_btn = 1'b1;
    do_reset(3);
    chk_all_zero("reset");
    while (cyc < 9) step();
    i_btn = 1'b0;
    while (cyc < 14) step();
    chk("s1_level_e14", o_level, 1'b0);
    chk("s1_click_e14", o_click, 1'b0);
    step();
    chk("s1_level_e15", o_level, 1'b1);
    chk("s1_click_e15", o_click, 1'b1);
    step();
    chk("s1_level_e16", o_level, 1'b1);
    chk("s1_click_e16", o_click, 1'b0);
    chk_int("s1_click_count", n_click, 1);

    // Three-cycle glitch is rejected.
    i_btn = 1'b1;
    do_reset(2);
    repeat (8) step();
    i_btn = 1'b0;
    repeat (3) step();
    i_btn = 1'b1;
    repeat (20) begin
      step();
      chk("s2_level_low", o_level, 1'b0);
    end
    chk_int("s2_clicks", n_click, 0);
    chk_int("s2_releases", n_rel, 0);

    // Bouncy press and bouncy release.
    i_btn = 1'b1;
    do_reset(2);
    repeat (5) step();
    for (int i = 0; i < 6; i++) begin
      i_btn = (i % 2 == 0) ? 1'b0 : 1'b1;
      step();
    end
    i_btn = 1'b0;
    repeat (20) step();
    chk("s3_level_pressed", o_level, 1'b1);
    for (int i = 0; i < 6; i++) begin
      i_btn = (i % 2 == 0) ? 1'b1 : 1'b0;
      step();
    end
    i_btn = 1'b1;
    k = cyc + 1;
    while (cyc < k + 4) step();
    chk("s3_release_before", o_release, 1'b0);
    step();
    chk("s3_release_at", o_release, 1'b1);
    chk("s3_level_released", o_level, 1'b0);
    step();
    chk("s3_release_after", o_release, 1'b0);
    while (cyc < k + 19) step();
    chk_int("s3_clicks", n_click, 1);
    chk_int("s3_releases", n_rel, 1);

    // Long hold: one long-press pulse 8 edges after the level rises.
    i_btn = 1'b1;
    do_reset(2);
    repeat (3) step();
    i_btn = 1'b0;
    k = cyc + 1;
    e = k + D + 1;
    while (cyc < e) step();
    chk("s4_level_rise", o_level, 1'b1);
    while (cyc < e + 7) step();
    chk("s4_long_before", o_long, 1'b0);
    step();
    chk("s4_long_at", o_long, LONG_ON);
    step();
    chk("s4_long_after", o_long, 1'b0);
    while (cyc < k + 29) step();
    chk_int("s4_long_count", n_long, LONG_ON ? 1 : 0);
    i_btn = 1'b1;
    repeat (10) step();

    // Reset mid-debounce, button kept held through it.
    i_btn = 1'b1;
    do_reset(2);
    repeat (3) step();
    i_btn = 1'b0;
    k = cyc + 1;
    while (cyc < k + 3) step();
    i_reset_n = 1'b0;
    step();
    chk_all_zero("s5_in_reset");
    do_reset(0);
    while (cyc < D + 1) step();
    chk("s5_click_before", o_click, 1'b0);
    chk("s5_level_before", o_level, 1'b0);
    step();
    chk("s5_click_at", o_click, 1'b1);
    chk("s5_level_at", o_level, 1'b1);
    chk_int("s5_click_count", n_click, 1);

    // Randomized pin activity with occasional resets.
    i_btn = 1'b1;
    do_reset(2);
    repeat (200) begin
      len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10, 40))
                                        : int'($urandom_range(1, 6));
      i_btn = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 24) == 0) i_reset_n = 1'b0;
      repeat (len) begin
        step();
        i_reset_n = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
